// File: rtl/add_arbiter_if.sv
// Request/response bundle between NREQ producers and the shared-adder arbiter.
interface add_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_data0;
    logic [NREQ*XLEN-1:0] req_data1;
    logic [NREQ-1:0]      req_op;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [XLEN-1:0]      resp_result;

    modport master (
        output req_valid, req_data0, req_data1, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub unit among NREQ
// requesters, returning a registered, id-tagged response.
module add #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data0,
    input  logic [XLEN-1:0] data1,
    input  logic            op,
    output logic [XLEN-1:0] result
);
    always_comb result = op ? (data0 - data1) : (data0 + data1);
endmodule

module add_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 4
) (
    input logic         clock,
    input logic         reset,
    add_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  ptr_next;
    logic [IDW:0]    idx;
    logic            found;
    logic            slot_free;
    logic            grant;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            op_sel;
    logic [XLEN-1:0] sum;

    // Search from ptr upward; the extra idx bit lets the wrap be an explicit
    // subtract of NREQ so non-power-of-two counts work.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && bus.req_valid[idx[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[IDW-1:0];
            end
        end
    end

    assign slot_free = !bus.resp_valid || bus.resp_ready;
    assign grant     = found && slot_free;
    assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        bus.req_ready = '0;
        if (grant)
            bus.req_ready[grant_id] = 1'b1;
    end

    assign op_a   = bus.req_data0[grant_id*XLEN +: XLEN];
    assign op_b   = bus.req_data1[grant_id*XLEN +: XLEN];
    assign op_sel = bus.req_op[grant_id];

    add #(.XLEN(XLEN)) u_add (
        .data0  (op_a),
        .data1  (op_b),
        .op     (op_sel),
        .result (sum)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_id     <= '0;
            bus.resp_result <= '0;
            ptr             <= '0;
        end else if (grant) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_id     <= grant_id;
            bus.resp_result <= sum;
            ptr             <= ptr_next;
        end else if (bus.resp_valid && bus.resp_ready) begin
            bus.resp_valid  <= 1'b0;
        end
    end
endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
Shares one combinational `add` unit (data0, data1, op, result) among NREQ independent requesters. Uses round-robin arbitration with per-requester valid/ready request handshakes. Returns the result through a single registered response port, tagged with the requester id. Sits between multiple producer blocks and the shared adder so that only one adder instance is needed.

Parameters:
XLEN, 32, operand and result width in bits; passed unchanged to the `add` instance.
NREQ, 4, number of requesters; must be at least 2; need not be a power of two.
IDW, $clog2(NREQ), width of the requester id; derived localparam, not overridden.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  NREQ  bit i: requester i presents an operation.
req_ready  output  NREQ  bit i: requester i is granted this cycle; at most one bit set.
req_data0  input  NREQ*XLEN  slice i: first operand of requester i.
req_data1  input  NREQ*XLEN  slice i: second operand of requester i.
req_op  input  NREQ  bit i: 0 = add, 1 = subtract (data0 - data1).
resp_valid  output  1  response register holds a result.
resp_ready  input  1  consumer accepts the response this cycle.
resp_id  output  IDW  index of the requester that produced the current response.
resp_result  output  XLEN  registered adder result.

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion):
  - resp_valid=0, resp_id=0, resp_result=0, round-robin pointer ptr=0.
  - Any pending response is discarded.
- Slot state:
  - slot_free = !resp_valid || resp_ready.
- Arbitration (combinational, every cycle):
  - Search req_valid starting at index ptr, ascending, wrapping NREQ-1 -> 0.
  - The first asserted index is g.
  - A grant occurs when at least one req_valid is set and slot_free=1.
- On grant:
  - req_ready[g]=1; all other req_ready bits are 0.
  - The adder input mux selects requester g's data0, data1 and op.
  - At the rising edge: resp_result <= add result, resp_id <= g, resp_valid <= 1, ptr <= (g+1) mod NREQ.
- No grant:
  - All req_ready=0.
  - ptr is unchanged.
  - If resp_valid && resp_ready, then resp_valid <= 0.
  - If resp_valid && !resp_ready, resp_result and resp_id are held stable.
- Latency and throughput:
  - Result is visible in the cycle after the grant (1-cycle latency).
  - Sustained throughput is one operation per cycle while resp_ready=1.
  - Accept and refill of the response register in the same cycle is required, with no bubble.
- Arithmetic:
  - Modulo 2^XLEN, identical to `add`. op=0 gives data0+data1; op=1 gives data0-data1.
  - No carry or borrow output.
- Handshake rules:
  - req_ready depends combinationally on req_valid and resp_ready.
  - Requesters must not derive req_valid from req_ready.
  - Once asserted, req_valid, data and op stay stable until the requester's req_ready is seen.
- Fairness:
  - A requester holding req_valid is granted within NREQ grants.
- Non-power-of-two NREQ:
  - Pointer wrap uses an explicit compare to NREQ-1, not bit truncation.

Test Plan:
1. Reset with XLEN=32, NREQ=4; assert reset mid-cycle while resp_valid=1 and resp_ready=0 -> resp_valid, resp_id and resp_result go to 0 at once; after release with all four requesters valid, the first grant goes to req 0.
2. Only req 0 valid:
   - 0x00000005 op=0 0x00000003 -> next cycle resp_valid=1, resp_id=0, resp_result=0x00000008.
   - op=1 -> resp_result=0x00000002.
   - 0xFFFFFFFF+0x00000001 -> 0x00000000.
   - 0x00000000-0x00000001 -> 0xFFFFFFFF.
3. All four requesters valid continuously, resp_ready=1 -> req_ready one-hot sequence 0,1,2,3,0,1...; resp_id follows one cycle later; one result per cycle; each result equals its requester's a op b.
4. Backpressure: resp_ready=0 for 5 cycles with resp_valid=1 -> req_ready=0000 throughout, and resp_id/resp_result stay stable; raise resp_ready -> next requester is granted in that same cycle, with no bubble.
5. Pointer wrap: set ptr=1 by granting req 0 first, then assert only req 0 and req 2 -> grant 2, then grant 0.
6. Random regression: 10000 cycles of random req_valid, operands, op and resp_ready (SEED-driven, with MAXTIME limit) -> every response matches a scoreboard of a+b / a-b per id, with zero mismatches; no requester waits more than NREQ grants.
